// File: rtl/loader_pkg.sv
// Shared loader/CPU-top definitions: loader FSM states and memory bus encodings.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_e;

    localparam logic [1:0] ACC_BYTE = 2'b00;
    localparam logic [1:0] ACC_WORD = 2'b11;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/prog_loader.sv
// Streams (address, byte) pairs into NUM_MEM memories in parallel, optionally reads
// each byte back and compares it, then hands the memory ports over to the CPU.
module prog_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int NUM_MEM = 2,
    parameter int VERIFY  = 1,
    parameter int RD_LAT  = 2,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_W-1:0]     in_addr,
    input  logic [7:0]            in_data,
    input  logic                  in_last,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [31:0]           mem_data_in,
    output logic [1:0]            mem_access_size,
    output logic                  mem_rw,
    input  logic [8*NUM_MEM-1:0]  mem_data_out,
    output logic                  cpu_sel,
    output logic                  cpu_stall,
    output logic                  done,
    output logic                  error,
    output logic [NUM_MEM-1:0]    err_mem,
    output logic [ADDR_W-1:0]     err_addr,
    output logic [CNT_W-1:0]      byte_count
);

    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_e               r_state;
    logic [ADDR_W-1:0]    r_addr;
    logic [7:0]           r_data;
    logic                 r_last;
    logic [LAT_W-1:0]     r_lat;
    logic [CNT_W-1:0]     r_byte_count;
    logic [NUM_MEM-1:0]   r_err_mem;
    logic [ADDR_W-1:0]    r_err_addr;
    logic [NUM_MEM-1:0]   w_mismatch;

    // Case equality so an X/Z readback lane is flagged rather than silently passing.
    for (genvar gi = 0; gi < NUM_MEM; gi++) begin : g_lane
        assign w_mismatch[gi] = !(mem_data_out[8*gi +: 8] === r_data);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_data       <= '0;
            r_last       <= 1'b0;
            r_lat        <= '0;
            r_byte_count <= '0;
            r_err_mem    <= '0;
            r_err_addr   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_addr  <= in_addr;
                        r_data  <= in_data;
                        r_last  <= in_last;
                        r_state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (r_byte_count != '1)
                        r_byte_count <= r_byte_count + CNT_W'(1);
                    if (VERIFY != 0) begin
                        r_lat   <= LAT_W'(RD_LAT - 1);
                        r_state <= ST_READ;
                    end else begin
                        r_state <= r_last ? ST_DONE : ST_IDLE;
                    end
                end
                ST_READ: begin
                    if (r_lat == '0) r_state <= ST_CHECK;
                    else             r_lat   <= r_lat - LAT_W'(1);
                end
                ST_CHECK: begin
                    if (|w_mismatch) begin
                        r_err_mem  <= w_mismatch;
                        r_err_addr <= r_addr;
                        r_state    <= ST_ERROR;
                    end else begin
                        r_state <= r_last ? ST_DONE : ST_IDLE;
                    end
                end
                ST_DONE, ST_ERROR: r_state <= r_state;
                default:           r_state <= ST_IDLE;
            endcase
        end
    end

    // Address/data only change on accept, so they hold outside WRITE/READ.
    assign mem_address     = r_addr;
    assign mem_data_in     = {24'b0, r_data};
    assign mem_access_size = ACC_BYTE;
    assign mem_rw          = (r_state == ST_WRITE) ? RW_WRITE : RW_READ;

    assign in_ready   = (r_state == ST_IDLE);
    assign done       = (r_state == ST_DONE);
    assign error      = (r_state == ST_ERROR);
    assign cpu_sel    = done;
    assign cpu_stall  = !done;
    assign err_mem    = r_err_mem;
    assign err_addr   = r_err_addr;
    assign byte_count = r_byte_count;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: verify-mode instance (a_*) with a behavioural memory model,
// plus a write-only, 2-bit-counter instance (b_*).
module tb_prog_loader;

    localparam int RD_LAT = 2;
    localparam int PER    = RD_LAT + 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic        a_rst_n, a_in_valid, a_in_ready, a_in_last, a_mem_rw;
    logic [31:0] a_in_addr, a_mem_address, a_mem_data_in, a_err_addr;
    logic [7:0]  a_in_data;
    logic [1:0]  a_mem_access_size, a_err_mem;
    logic [15:0] a_mem_data_out, a_byte_count;
    logic        a_cpu_sel, a_cpu_stall, a_done, a_error;

    logic        b_rst_n, b_in_valid, b_in_ready, b_in_last, b_mem_rw;
    logic [31:0] b_in_addr, b_mem_address, b_mem_data_in, b_err_addr;
    logic [7:0]  b_in_data;
    logic [1:0]  b_mem_access_size, b_err_mem, b_byte_count;
    logic [15:0] b_mem_data_out;
    logic        b_cpu_sel, b_cpu_stall, b_done, b_error;

    prog_loader #(.ADDR_W(32), .NUM_MEM(2), .VERIFY(1), .RD_LAT(RD_LAT), .CNT_W(16)) u_a (
        .clk(clk), .rst_n(a_rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_addr(a_in_addr), .in_data(a_in_data), .in_last(a_in_last),
        .mem_address(a_mem_address), .mem_data_in(a_mem_data_in),
        .mem_access_size(a_mem_access_size), .mem_rw(a_mem_rw), .mem_data_out(a_mem_data_out),
        .cpu_sel(a_cpu_sel), .cpu_stall(a_cpu_stall), .done(a_done), .error(a_error),
        .err_mem(a_err_mem), .err_addr(a_err_addr), .byte_count(a_byte_count)
    );

    assign b_mem_data_out = '0;
    prog_loader #(.ADDR_W(32), .NUM_MEM(2), .VERIFY(0), .RD_LAT(RD_LAT), .CNT_W(2)) u_b (
        .clk(clk), .rst_n(b_rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_addr(b_in_addr), .in_data(b_in_data), .in_last(b_in_last),
        .mem_address(b_mem_address), .mem_data_in(b_mem_data_in),
        .mem_access_size(b_mem_access_size), .mem_rw(b_mem_rw), .mem_data_out(b_mem_data_out),
        .cpu_sel(b_cpu_sel), .cpu_stall(b_cpu_stall), .done(b_done), .error(b_error),
        .err_mem(b_err_mem), .err_addr(b_err_addr), .byte_count(b_byte_count)
    );

    // Two byte-wide memories over a 256-byte window, fixed read latency, optional
    // forced readback value on selected lanes at one address.
    logic [7:0]  m0 [256];
    logic [7:0]  m1 [256];
    logic [15:0] rp [RD_LAT];
    logic [1:0]  cor_mask = 2'b00;
    logic [31:0] cor_addr = '0;
    logic [7:0]  cor_val  = '0;
    logic [7:0]  lane0, lane1;
    wire  [7:0]  a_idx = a_mem_address[7:0];
    wire         cor_hit = (a_mem_address == cor_addr);

    assign lane0 = (cor_mask[0] && cor_hit) ? cor_val : m0[a_idx];
    assign lane1 = (cor_mask[1] && cor_hit) ? cor_val : m1[a_idx];
    assign a_mem_data_out = rp[RD_LAT-1];

    always @(posedge clk) begin
        if (!a_mem_rw) begin
            m0[a_idx] <= a_mem_data_in[7:0];
            m1[a_idx] <= a_mem_data_in[7:0];
        end
        rp[0] <= {lane1, lane0};
        for (int i = 1; i < RD_LAT; i++) rp[i] <= rp[i-1];
    end

    int b_wr_q[$];
    always @(negedge clk) if (b_rst_n && !b_mem_rw) b_wr_q.push_back(cyc);

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
        logic [1:0]  cmask;
        logic [7:0]  cval;
        logic        exp_err;
        logic [1:0]  exp_mem;
    } vec_t;
    vec_t vt[5];

    logic [7:0] exp_mem[256];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input bit b);
        if (b) begin b_rst_n = 0; b_in_valid = 0; b_in_last = 0; b_in_addr = '0; b_in_data = '0; end
        else   begin a_rst_n = 0; a_in_valid = 0; a_in_last = 0; a_in_addr = '0; a_in_data = '0; end
        repeat (2) @(negedge clk);
        if (b) b_rst_n = 1; else a_rst_n = 1;
        @(negedge clk);
    endtask

    // Present a byte and hold it until taken; returns the cycle of the accepting IDLE.
    task automatic send(input bit b, input logic [31:0] addr, input logic [7:0] data,
                        input logic last, output int t_acc);
        int n = 0;
        if (b) begin b_in_valid = 1; b_in_addr = addr; b_in_data = data; b_in_last = last; end
        else   begin a_in_valid = 1; a_in_addr = addr; a_in_data = data; a_in_last = last; end
        while (!(b ? b_in_ready : a_in_ready) && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready never rose, want 1");
        end
        t_acc = cyc;
        @(negedge clk);
        if (b) b_in_valid = 0; else a_in_valid = 0;
    endtask

    task automatic wait_end(input bit b, output int t_end, output logic prev_sel);
        int n = 0;
        prev_sel = b ? b_cpu_sel : a_cpu_sel;
        while (!(b ? (b_done | b_error) : (a_done | a_error)) && n < 300) begin
            prev_sel = b ? b_cpu_sel : a_cpu_sel;
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++; errors++;
            $display("FAIL end_timeout: neither done nor error rose, want one");
        end
        t_end = cyc;
    endtask

    initial begin
        int t0, t, te, n;
        logic ps, hold_ok;

        vt[0] = '{32'h8002_0010, 8'hA5, 2'b00, 8'h00, 1'b0, 2'b00};
        vt[1] = '{32'h8002_0011, 8'h00, 2'b01, 8'h01, 1'b1, 2'b01};
        vt[2] = '{32'h8002_0012, 8'hFF, 2'b10, 8'h7F, 1'b1, 2'b10};
        vt[3] = '{32'h8002_00FF, 8'h3C, 2'b11, 8'hC3, 1'b1, 2'b11};
        vt[4] = '{32'h8002_0020, 8'h5A, 2'b01, 8'h5A, 1'b0, 2'b00};

        fork do_reset(0); do_reset(1); join

        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_mem_rw", a_mem_rw, 1);
        chk("rst_mem_address", a_mem_address, 0);
        chk("rst_mem_data_in", a_mem_data_in, 0);
        chk("rst_access_size", a_mem_access_size, 0);
        chk("rst_cpu_sel", a_cpu_sel, 0);
        chk("rst_cpu_stall", a_cpu_stall, 1);
        chk("rst_done_error", {a_done, a_error}, 0);
        chk("rst_err_fields", {a_err_mem, a_err_addr}, 0);
        chk("rst_byte_count", a_byte_count, 0);
        chk("rst_b_state", {b_in_ready, b_mem_rw, b_cpu_stall, b_byte_count}, 5'b11100);

        // Eight-byte image, both lanes good.
        for (int i = 0; i < 8; i++) begin
            send(0, 32'h8002_0000 + i, 8'(i), i == 7, t);
            if (i == 0) t0 = t;
        end
        wait_end(0, te, ps);
        chk("wv_done_latency", te - t0, 8 * PER);
        chk("wv_done", {a_done, a_error}, 2'b10);
        chk("wv_byte_count", a_byte_count, 8);
        chk("wv_sel_rise", {ps, a_cpu_sel, a_cpu_stall}, 3'b010);
        chk("wv_in_ready", a_in_ready, 0);
        for (int i = 0; i < 8; i++) chk("wv_mem", {m1[i], m0[i]}, {8'(i), 8'(i)});

        // Lane 1 reads back 0xFF at byte 3.
        do_reset(0);
        cor_mask = 2'b10; cor_addr = 32'h8002_0003; cor_val = 8'hFF;
        for (int i = 0; i < 4; i++) send(0, 32'h8002_0000 + i, 8'(i), 1'b0, t);
        wait_end(0, te, ps);
        chk("lm_error", {a_error, a_done}, 2'b10);
        chk("lm_err_mem", a_err_mem, 2'b10);
        chk("lm_err_addr", a_err_addr, 32'h8002_0003);
        chk("lm_byte_count", a_byte_count, 4);
        repeat (20) @(negedge clk);
        chk("lm_sticky", {a_error, a_done, a_in_ready, a_cpu_stall, a_cpu_sel}, 5'b10010);
        cor_mask = 2'b00;

        // Single-byte images from the table.
        for (int v = 0; v < 5; v++) begin
            do_reset(0);
            cor_mask = vt[v].cmask; cor_addr = vt[v].addr; cor_val = vt[v].cval;
            send(0, vt[v].addr, vt[v].data, 1'b1, t);
            wait_end(0, te, ps);
            chk("tbl_latency", te - t, PER);
            chk("tbl_done_error", {a_done, a_error}, {!vt[v].exp_err, vt[v].exp_err});
            chk("tbl_err_mem", a_err_mem, vt[v].exp_mem);
            chk("tbl_err_addr", a_err_addr, vt[v].exp_err ? vt[v].addr : 32'h0);
            chk("tbl_count_sel", {a_byte_count, a_cpu_sel}, {16'd1, !vt[v].exp_err});
            cor_mask = 2'b00;
        end

        // Changing data offered while busy must not be taken.
        do_reset(0);
        send(0, 32'h8002_0040, 8'h11, 1'b0, t);
        a_in_valid = 1; a_in_addr = 32'h8002_0041; a_in_last = 1; n = 0; hold_ok = 1;
        while (!a_in_ready && n < 20) begin
            a_in_data = 8'($urandom);
            if (a_mem_address != 32'h8002_0040) hold_ok = 0;
            @(negedge clk); n++;
        end
        chk("bp_wait_cycles", n, PER - 1);
        chk("bp_addr_hold", hold_ok, 1);
        a_in_data = 8'h22;
        @(negedge clk);
        a_in_valid = 0;
        wait_end(0, te, ps);
        chk("bp_done_count", {a_done, a_byte_count}, {1'b1, 16'd2});
        chk("bp_mem", {m0[8'h40], m0[8'h41], m1[8'h41]}, 24'h11_2222);

        // Reset during the second READ cycle of the third byte.
        do_reset(0);
        for (int i = 0; i < 3; i++) send(0, 32'h8002_0050 + i, 8'hA0 + 8'(i), 1'b0, t);
        repeat (2) @(negedge clk);
        a_rst_n = 0;
        #1;
        chk("mr_idle", {a_in_ready, a_mem_rw, a_cpu_sel, a_cpu_stall}, 4'b1101);
        chk("mr_byte_count", a_byte_count, 0);
        chk("mr_kept_image", m0[8'h50], 8'hA0);
        @(negedge clk);
        a_rst_n = 1;
        @(negedge clk);
        send(0, 32'h8002_0060, 8'h5C, 1'b0, t0);
        send(0, 32'h8002_0061, 8'hC5, 1'b1, t);
        wait_end(0, te, ps);
        chk("mr_fresh_done", {a_done, a_byte_count}, {1'b1, 16'd2});
        chk("mr_fresh_latency", te - t0, 2 * PER);
        chk("mr_fresh_mem", {m0[8'h60], m1[8'h61]}, 16'h5CC5);

        // Write-only instance: four writes, then saturation.
        do_reset(1);
        b_wr_q.delete();
        for (int i = 0; i < 4; i++) begin
            send(1, 32'h8002_0070 + i, 8'(i), i == 3, t);
            if (i == 0) t0 = t;
        end
        wait_end(1, te, ps);
        chk("nv_done_latency", te - t0, 8);
        chk("nv_write_count", b_wr_q.size(), 4);
        if (b_wr_q.size() == 4) begin
            chk("nv_first_write", b_wr_q[0] - t0, 1);
            for (int i = 1; i < 4; i++) chk("nv_write_spacing", b_wr_q[i] - b_wr_q[i-1], 2);
        end
        chk("nv_sel", {ps, b_cpu_sel, b_done}, 3'b011);

        do_reset(1);
        for (int i = 0; i < 5; i++) send(1, 32'h8002_0080 + i, 8'(i), i == 4, t);
        wait_end(1, te, ps);
        chk("sat_count_done", {b_byte_count, b_done}, 3'b111);

        // Random images against the outcome model.
        for (int i = 0; i < 256; i++) exp_mem[i] = m0[i];
        for (int r = 0; r < 25; r++) begin
            int len, k, nsend;
            logic corrupt;
            logic [31:0] base;
            logic [7:0]  d [6];
            logic [1:0]  msk;
            len  = $urandom_range(1, 6);
            corrupt = 1'($urandom_range(0, 1));
            k    = $urandom_range(0, len - 1);
            msk  = 2'($urandom_range(1, 3));
            base = 32'h8002_0000 | 32'($urandom_range(0, 240));
            for (int i = 0; i < len; i++) d[i] = 8'($urandom);
            nsend = corrupt ? k + 1 : len;
            do_reset(0);
            cor_mask = corrupt ? msk : 2'b00;
            cor_addr = base + k;
            cor_val  = d[k] ^ 8'($urandom_range(1, 255));
            for (int i = 0; i < nsend; i++) begin
                repeat ($urandom_range(0, 6)) @(negedge clk);
                send(0, base + i, d[i], i == len - 1, t);
                exp_mem[8'(base[7:0] + 8'(i))] = d[i];
            end
            wait_end(0, te, ps);
            chk("rnd_latency", te - t, PER);
            chk("rnd_outcome", {a_done, a_error}, {!corrupt, corrupt});
            chk("rnd_err", {a_err_mem, a_err_addr}, corrupt ? {msk, base + 32'(k)} : 34'h0);
            chk("rnd_byte_count", a_byte_count, 16'(nsend));
            for (int i = 0; i < nsend; i++) begin
                logic [7:0] ix;
                ix = 8'(base[7:0] + 8'(i));
                chk("rnd_mem", {m1[ix], m0[ix]}, {exp_mem[ix], exp_mem[ix]});
            end
            cor_mask = 2'b00;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Synthesizable program loader that replaces the behavioural SREC-to-memory sequence in the CPU top. It takes a byte stream of (address, data) pairs over a valid/ready handshake and writes each byte to `NUM_MEM` memories in parallel on a shared bus. When `VERIFY` is set, it reads each byte back from every memory and compares it. On success it hands memory ownership to the CPU by raising `cpu_sel` and dropping `cpu_stall`; on a mismatch it halts with a sticky error.

## Interface
Parameters:
- `ADDR_W`, 32, memory address width
- `NUM_MEM`, 2, number of memories written in parallel (instruction + data), ≥1
- `VERIFY`, 1, 1 = read back and compare every byte; 0 = write only
- `RD_LAT`, 2, cycles from `mem_rw`=1 to valid `mem_data_out`, ≥1
- `CNT_W`, 16, width of `byte_count`

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `in_valid` in 1: stream byte valid
- `in_ready` out 1: loader accepts a byte
- `in_addr` in `ADDR_W`: byte address
- `in_data` in 8: byte value
- `in_last` in 1: marks the final byte of the image
- `mem_address` out `ADDR_W`: shared memory address
- `mem_data_in` out 32: `{24'b0, byte}`
- `mem_access_size` out 2: constant `2'b00` (byte)
- `mem_rw` out 1: 0 = write, 1 = read
- `mem_data_out` in `8*NUM_MEM`: low byte of each memory's read data, lane *i* at [8i+7:8i]
- `cpu_sel` out 1: 0 = loader owns memory ports, 1 = CPU owns them
- `cpu_stall` out 1: holds all pipeline stages
- `done` out 1: image loaded (and verified if enabled)
- `error` out 1: readback mismatch, sticky
- `err_mem` out `NUM_MEM`: mismatching lanes of the failing byte
- `err_addr` out `ADDR_W`: address of the failing byte
- `byte_count` out `CNT_W`: bytes written, saturating

## Operation
- States: IDLE, WRITE, READ, CHECK, DONE, ERROR.
- **IDLE**: `in_ready`=1. On `in_valid & in_ready`, latch addr, data and last, then go to WRITE.
- **WRITE**: one cycle with `mem_rw`=0 and the latched address and data on the bus; `byte_count` increments, saturating at all-ones.
  - `VERIFY`=1: go to READ.
  - `VERIFY`=0: go to DONE if last, else IDLE.
- **READ**: `mem_rw`=1, same address, held for `RD_LAT` cycles (down-counter), then go to CHECK.
- **CHECK**: compare each lane of `mem_data_out` with the latched byte; `mem_rw` stays 1.
  - All lanes equal: go to DONE if last, else IDLE.
  - Any lane differs: load `err_mem` with the per-lane mismatch mask and `err_addr` with the address, then go to ERROR.
  - X/Z on a lane counts as a mismatch in simulation.
- **DONE**: terminal until reset. `done`=1, `cpu_sel`=1, `cpu_stall`=0, `in_ready`=0.
- **ERROR**: terminal until reset. `error`=1, `cpu_sel`=0, `cpu_stall`=1, `in_ready`=0.
- In every state except DONE, `cpu_sel`=0 and `cpu_stall`=1.
- In IDLE, `mem_rw`=1 (a read, so memory is never disturbed).
- `mem_address` and `mem_data_in` hold their last values outside WRITE/READ.

## Timing
- Reset values:
  - state IDLE; `in_ready`=1; `mem_rw`=1
  - `mem_address`=0, `mem_data_in`=0, `mem_access_size`=`2'b00`
  - `cpu_sel`=0, `cpu_stall`=1, `done`=0, `error`=0
  - `err_mem`=0, `err_addr`=0, `byte_count`=0
- All outputs are registered or decoded from state; no combinational path from input to output except none (`in_ready` is decoded from state).
- Cycles per byte, including the accept cycle:
  - `VERIFY`=1: `RD_LAT`+3 (5 at default).
  - `VERIFY`=0: 2.
- A back-to-back stream is accepted at most once per byte period; `in_valid` while `in_ready`=0 is ignored, and the source must hold the byte.
- `done` and `cpu_sel` rise in the same cycle, one cycle after the last CHECK (or last WRITE when `VERIFY`=0).
- `rst_n` asserted mid-write or mid-read: immediately return to IDLE, release the bus to read, and clear all status. The partial image is not erased.
- `byte_count` wraps never; it saturates.
- `in_last` on the very first byte gives a one-byte image.

## Structure
- `loader_pkg` holds:
  - the state enum;
  - `ACC_BYTE`=`2'b00`, `ACC_WORD`=`2'b11`;
  - `RW_WRITE`=0, `RW_READ`=1.
- These are shared with fetch/exec and the memory muxes in the CPU top.
- Single module, no sub-module; the per-lane compare is a generate loop.
- The CPU-top memory muxes use `cpu_sel` as their select, and the stage stalls OR in `cpu_stall`.

## Test plan
- **Write and verify**: stream 8 bytes `0x00–0x07` to addresses `0x80020000–0x80020007`, `NUM_MEM`=2, `RD_LAT`=2, both memories model correctly → each byte appears in both; `done`=1 exactly 40 cycles after the first accept; `byte_count`=8; `cpu_sel` 0→1 in the same cycle as `done`.
- **Lane mismatch**: force memory 1's readback of address `0x80020003` to `0xFF` (written `0x03`) → `error`=1, `err_mem`=`2'b10`, `err_addr`=`0x80020003`, `cpu_stall` stays 1, `in_ready` stays 0, `done` never rises.
- **No verify**: `VERIFY`=0, 4 bytes with `in_valid` held high → `mem_rw` low for exactly 4 single cycles spaced 2 apart, no read cycles, `done` 8 cycles after the first accept.
- **Handshake backpressure**: assert `in_valid` with changing data during READ → the byte is not taken; it is accepted only on the next IDLE cycle, and memory holds the held value.
- **Mid-operation reset**: pulse `rst_n` low during the second READ cycle of byte 3 → the same cycle shows IDLE, `in_ready`=1, `mem_rw`=1, `byte_count`=0, `cpu_sel`=0; a fresh 2-byte image then completes normally.
- **Saturation**: `CNT_W`=2, stream 5 bytes → `byte_count` stops at 3 and `done`=1.
